kyber_encrypt_seq: RTL and testbench

- Parametrised, sequential successor to the Baby-Kyber encrypt datapath.
- Computes the ciphertext:
  - u = Aᵀ·r + e1 (vector of K polynomials)
  - v = tᵀ·r + e2 + msg·QHALF (one polynomial)
- All arithmetic is in Z_Q[x]/(x^N+1).
- One shared multiply-accumulate unit is time-multiplexed. Valid/ready handshakes sit on both input and output.
- Sits between the key/noise sampler and the ciphertext serializer.

---
 rtl/kyber_encrypt_seq.sv | 208 ++++++++++++++++++++
 tb/tb_kyber_encrypt_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kyber_encrypt_seq.sv
// Sequential Baby-Kyber encryption datapath.
// A single multiply-accumulate unit produces every ciphertext coefficient in turn:
//   u[row] = sum_k A[k][row] * r[k] + e1[row]         (row < K)
//   v      = sum_k t[k] * r[k] + e2 + msg * QHALF     (row == K)
// Arithmetic is in Z_Q[x]/(x^N+1). The accumulator runs unreduced, and each
// finished coefficient is folded into [0, Q-1] once.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | in_ready=1, waiting for an input transaction
// MAC    | one signed product per cycle into acc (m = 0 .. K*N-1)
// FIN    | add noise/message, reduce mod Q, write one coefficient
// DONE   | out_valid=1, ciphertext held until out_ready
module kyber_encrypt_seq #(
    parameter int K = 2,
    parameter int N = 4,
    parameter int Q = 17,
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [K*K*N*W-1:0]   pk_a,
    input  logic [K*N*W-1:0]     pk_t,
    input  logic [K*N*W-1:0]     r,
    input  logic [K*N*W-1:0]     e1,
    input  logic [N*W-1:0]       e2,
    input  logic [N-1:0]         msg,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [K*N*W-1:0]     ct_u,
    output logic [N*W-1:0]       ct_v
);

    localparam int QHALF = (Q + 1) / 2;
    localparam int ACC_W = 2 * W + $clog2(K * N) + 2;
    localparam int IW    = (N > 1) ? $clog2(N) : 1;
    localparam int MW    = (K * N > 1) ? $clog2(K * N) : 1;
    localparam int RW    = $clog2(K + 1);

    localparam logic signed [ACC_W-1:0] Q_S  = ACC_W'(Q);
    localparam logic signed [ACC_W-1:0] QH_S = ACC_W'(QHALF);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_FIN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [K*K*N*W-1:0]       r_pk_a;
    logic [K*N*W-1:0]         r_pk_t;
    logic [K*N*W-1:0]         r_rv;
    logic [K*N*W-1:0]         r_e1;
    logic [N*W-1:0]           r_e2;
    logic [N-1:0]             r_msg;
    logic [K*N*W-1:0]         r_ct_u;
    logic [N*W-1:0]           r_ct_v;
    logic signed [ACC_W-1:0]  r_acc;
    logic [RW-1:0]            r_row;
    logic [IW-1:0]            r_i;
    logic [MW-1:0]            r_m;

    logic                     w_accept;
    logic                     w_last_m;
    logic                     w_last_coef;
    int                       w_k;
    int                       w_j;
    int                       w_bi;
    logic [W-1:0]             w_a;
    logic signed [W-1:0]      w_b;
    logic signed [2*W:0]      w_prod;
    logic                     w_neg;
    logic signed [W-1:0]      w_noise;
    logic                     w_msg_bit;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_rem;
    logic signed [ACC_W-1:0]  w_mod;
    logic [W-1:0]             w_res;

    assign in_ready    = (r_state == S_IDLE);
    assign busy        = (r_state == S_MAC) || (r_state == S_FIN);
    assign out_valid   = (r_state == S_DONE);
    assign ct_u        = r_ct_u;
    assign ct_v        = r_ct_v;
    assign w_accept    = in_valid && in_ready;
    assign w_last_m    = (r_m == MW'(K * N - 1));
    assign w_last_coef = (r_row == RW'(K)) && (r_i == IW'(N - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_MAC;
            S_MAC:  if (w_last_m) w_state_nxt = S_FIN;
            S_FIN:  w_state_nxt = w_last_coef ? S_DONE : S_MAC;
            S_DONE: if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand selection and signed product. The transpose of A is read by
    // swapping the row/col roles in the element index; row K selects t.
    always_comb begin
        w_k  = int'(r_m) / N;
        w_j  = int'(r_m) % N;
        w_bi = (int'(r_i) + N - w_j) % N;
        if (int'(r_row) < K) begin
            w_a = r_pk_a[((w_k * K + int'(r_row)) * N + w_j) * W +: W];
        end else begin
            w_a = r_pk_t[(w_k * N + w_j) * W +: W];
        end
        w_b    = r_rv[(w_k * N + w_bi) * W +: W];
        w_prod = $signed({1'b0, w_a}) * w_b;
        // Terms whose degree j + (i-j) wrapped past N pick up x^N = -1.
        w_neg  = (w_j > int'(r_i));
    end

    // Noise/message add and true modulus of the finished coefficient.
    always_comb begin
        w_msg_bit = 1'b0;
        if (int'(r_row) < K) begin
            w_noise = r_e1[(int'(r_row) * N + int'(r_i)) * W +: W];
        end else begin
            w_noise   = r_e2[int'(r_i) * W +: W];
            w_msg_bit = r_msg[r_i];
        end
        w_sum = r_acc + ACC_W'(w_noise) + (w_msg_bit ? QH_S : '0);
        // Signed % keeps the dividend's sign; fold negatives back into range.
        w_rem = w_sum % Q_S;
        w_mod = (w_rem < 0) ? (w_rem + Q_S) : w_rem;
        w_res = W'(w_mod);
    end

    // Input capture, accumulator, counters and ciphertext registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pk_a <= '0;
            r_pk_t <= '0;
            r_rv   <= '0;
            r_e1   <= '0;
            r_e2   <= '0;
            r_msg  <= '0;
            r_ct_u <= '0;
            r_ct_v <= '0;
            r_acc  <= '0;
            r_row  <= '0;
            r_i    <= '0;
            r_m    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_pk_a <= pk_a;
                        r_pk_t <= pk_t;
                        r_rv   <= r;
                        r_e1   <= e1;
                        r_e2   <= e2;
                        r_msg  <= msg;
                        r_acc  <= '0;
                        r_row  <= '0;
                        r_i    <= '0;
                        r_m    <= '0;
                    end
                end
                S_MAC: begin
                    if (w_neg) begin
                        r_acc <= r_acc - ACC_W'(w_prod);
                    end else begin
                        r_acc <= r_acc + ACC_W'(w_prod);
                    end
                    r_m <= r_m + MW'(1);
                end
                S_FIN: begin
                    if (int'(r_row) < K) begin
                        r_ct_u[(int'(r_row) * N + int'(r_i)) * W +: W] <= w_res;
                    end else begin
                        r_ct_v[int'(r_i) * W +: W] <= w_res;
                    end
                    r_acc <= '0;
                    r_m   <= '0;
                    if (r_i == IW'(N - 1)) begin
                        r_i <= '0;
                        if (!w_last_coef) r_row <= r_row + RW'(1);
                    end else begin
                        r_i <= r_i + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kyber_encrypt_seq.sv
// Testbench for kyber_encrypt_seq: directed vector table, hand-written
// backpressure and reset sequences, and random transactions checked against
// a schoolbook negacyclic reference model through an expected-result queue.
module tb_kyber_encrypt_seq;

    localparam int K   = 2;
    localparam int N   = 4;
    localparam int Q   = 17;
    localparam int W   = 16;
    localparam int AW  = K * K * N * W;
    localparam int VW  = K * N * W;
    localparam int PW  = N * W;
    localparam int LAT = (K + 1) * N * (K * N + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] pk_a = '0;
    logic [VW-1:0] pk_t = '0;
    logic [VW-1:0] r = '0;
    logic [VW-1:0] e1 = '0;
    logic [PW-1:0] e2 = '0;
    logic [N-1:0]  msg = '0;
    logic          busy;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [VW-1:0] ct_u;
    logic [PW-1:0] ct_v;

    always #5 clk = ~clk;

    kyber_encrypt_seq #(.K(K), .N(N), .Q(Q), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pk_a      (pk_a),
        .pk_t      (pk_t),
        .r         (r),
        .e1        (e1),
        .e2        (e2),
        .msg       (msg),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ct_u      (ct_u),
        .ct_v      (ct_v)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [VW-1:0] t;
        logic [VW-1:0] rv;
        logic [VW-1:0] e1v;
        logic [PW-1:0] e2v;
        logic [N-1:0]  m;
        logic [VW-1:0] exp_u;
        logic [PW-1:0] exp_v;
    } vec_t;

    typedef struct {
        logic [VW-1:0] u;
        logic [PW-1:0] v;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[4];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        pk_a = v.a;
        pk_t = v.t;
        r    = v.rv;
        e1   = v.e1v;
        e2   = v.e2v;
        msg  = v.m;
    endtask

    // Schoolbook product with x^N = -1, then noise, message and true mod Q.
    task automatic model(inout vec_t v);
        longint acc[N];
        longint av, rvv, s;
        for (int row = 0; row <= K; row++) begin
            for (int c = 0; c < N; c++) acc[c] = 0;
            for (int k = 0; k < K; k++) begin
                for (int x = 0; x < N; x++) begin
                    for (int y = 0; y < N; y++) begin
                        if (row < K) av = longint'(v.a[((k * K + row) * N + x) * W +: W]);
                        else         av = longint'(v.t[(k * N + x) * W +: W]);
                        rvv = longint'($signed(v.rv[(k * N + y) * W +: W]));
                        if (x + y < N) acc[x + y]     += av * rvv;
                        else           acc[x + y - N] -= av * rvv;
                    end
                end
            end
            for (int c = 0; c < N; c++) begin
                if (row < K) begin
                    s = acc[c] + longint'($signed(v.e1v[(row * N + c) * W +: W]));
                end else begin
                    s = acc[c] + longint'($signed(v.e2v[c * W +: W]));
                    if (v.m[c]) s += (Q + 1) / 2;
                end
                s = ((s % Q) + Q) % Q;
                if (row < K) v.exp_u[(row * N + c) * W +: W] = W'(s);
                else         v.exp_v[c * W +: W] = W'(s);
            end
        end
    endtask

    task automatic gen_random(output vec_t v);
        v = '{default: '0};
        for (int e = 0; e < K * K * N; e++) v.a[e * W +: W] = W'($urandom_range(0, Q - 1));
        for (int e = 0; e < K * N; e++) begin
            v.t[e * W +: W]   = W'($urandom_range(0, Q - 1));
            v.rv[e * W +: W]  = W'($urandom_range(0, 4)) - W'(2);
            v.e1v[e * W +: W] = W'($urandom_range(0, 4)) - W'(2);
        end
        for (int e = 0; e < N; e++) v.e2v[e * W +: W] = W'($urandom_range(0, 4)) - W'(2);
        v.m = N'($urandom_range(0, (1 << N) - 1));
        model(v);
    endtask

    // Pops the scoreboard and compares the ciphertext currently on the bus.
    task automatic compare_out(input string tag);
        exp_t e;
        logic ok;
        if (sb.size() == 0) begin
            check({tag, " scoreboard_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        check({tag, " ct_u"}, ct_u, e.u);
        check({tag, " ct_v"}, VW'(ct_v), VW'(e.v));
        ok = 1'b1;
        for (int c = 0; c < K * N; c++) if (ct_u[c * W +: W] >= W'(Q)) ok = 1'b0;
        for (int c = 0; c < N; c++)     if (ct_v[c * W +: W] >= W'(Q)) ok = 1'b0;
        check({tag, " range"}, VW'(ok), 1);
    endtask

    // Accepts one transaction, waits for out_valid with a bound, checks it.
    task automatic run_txn(input vec_t v, input bit early, input string tag);
        exp_t e;
        int   lat;
        @(negedge clk);
        drive(v);
        check({tag, " in_ready"}, VW'(in_ready), 1);
        in_valid  = 1'b1;
        out_ready = early;
        @(posedge clk);
        e.u = v.exp_u;
        e.v = v.exp_v;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < LAT + 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, VW'(lat), VW'(LAT));
        if (out_valid) compare_out(tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid_drop"}, VW'(out_valid), 0);
        check({tag, " back_to_idle"}, VW'(in_ready), 1);
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   lat;

        // Directed table: {inputs, expected outputs}.
        for (int i = 0; i < 4; i++) tbl[i] = '{default: '0};
        tbl[0].m     = 4'b1010;
        tbl[0].exp_v = {16'd9, 16'd0, 16'd9, 16'd0};
        tbl[1].a     = AW'(1) << 48;
        tbl[1].rv    = VW'(1) << 16;
        tbl[1].exp_u = VW'(16);
        tbl[2].e1v   = VW'(16'hFFFB) << 96;
        tbl[2].exp_u = VW'(12) << 96;
        tbl[3].t     = VW'(2) << 64;
        tbl[3].rv    = VW'(3) << 112;
        tbl[3].e2v   = PW'(16'hFFFF);
        tbl[3].m     = 4'b0001;
        tbl[3].exp_v = {16'd6, 16'd0, 16'd0, 16'd8};

        #2 rst_n = 1'b0;
        #1;
        check("rst out_valid", VW'(out_valid), 0);
        check("rst busy", VW'(busy), 0);
        check("rst ct_u", ct_u, '0);
        check("rst ct_v", VW'(ct_v), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst in_ready", VW'(in_ready), 1);

        for (int i = 0; i < 4; i++) begin
            run_txn(tbl[i], (i % 2) == 1, $sformatf("vec%0d", i));
        end

        // Backpressure: out_ready held low while in_valid toggles with other data.
        @(negedge clk);
        drive(tbl[1]);
        in_valid = 1'b1;
        @(posedge clk);
        sb.push_back('{u: tbl[1].exp_u, v: tbl[1].exp_v});
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < LAT + 50) begin
            @(negedge clk);
            lat++;
        end
        check("bp latency", VW'(lat), VW'(LAT));
        for (int c = 0; c < 20; c++) begin
            drive(tbl[2]);
            in_valid = (c % 2) == 0;
            @(negedge clk);
            check("bp out_valid_held", VW'(out_valid), 1);
            check("bp in_ready_low", VW'(in_ready), 0);
            check("bp ct_u_stable", ct_u, tbl[1].exp_u);
            check("bp ct_v_stable", VW'(ct_v), VW'(tbl[1].exp_v));
        end
        in_valid = 1'b0;
        compare_out("bp");
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp released", VW'(out_valid), 0);
        check("bp idle", VW'(in_ready), 1);
        run_txn(tbl[3], 1'b0, "bp_next");

        for (int n = 0; n < 200; n++) begin
            gen_random(v);
            run_txn(v, $urandom_range(0, 1) == 1, $sformatf("rnd%0d", n));
        end

        // Reset in the middle of the MAC phase.
        gen_random(v);
        @(negedge clk);
        drive(v);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (49) @(negedge clk);
        check("mid busy", VW'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst out_valid", VW'(out_valid), 0);
        check("mid rst busy", VW'(busy), 0);
        check("mid rst ct_u", ct_u, '0);
        check("mid rst ct_v", VW'(ct_v), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid rst in_ready", VW'(in_ready), 1);
        gen_random(v);
        run_txn(v, 1'b0, "post_rst");

        check("scoreboard drained", VW'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
